// File: rtl/reset_seq_ctrl_if.sv
// Bundle of the sequencer's lock/soft-reset inputs and reset/status outputs.
// wdog_kick_i exists only when RST_SEQ_WDOG_EN is defined.
interface reset_seq_ctrl_if #(
   parameter int N_RST = 3
);
   logic             locked_i;
   logic             soft_rst_i;
`ifdef RST_SEQ_WDOG_EN
   logic             wdog_kick_i;
`endif
   logic [N_RST-1:0] rst_o;
   logic             busy_o;
   logic [1:0]       cause_o;

`ifdef RST_SEQ_WDOG_EN
   modport master (input locked_i, soft_rst_i, wdog_kick_i,
                   output rst_o, busy_o, cause_o);
   modport slave  (output locked_i, soft_rst_i, wdog_kick_i,
                   input rst_o, busy_o, cause_o);
`else
   modport master (input locked_i, soft_rst_i,
                   output rst_o, busy_o, cause_o);
   modport slave  (output locked_i, soft_rst_i,
                   input rst_o, busy_o, cause_o);
`endif
endinterface

// File: rtl/reset_seq_ctrl.sv
// Board reset sequencer: syncs reset/lock, holds, then releases N_RST domains staggered.
// Optional watchdog re-entry is enabled by defining RST_SEQ_WDOG_EN.
module reset_seq_ctrl #(
   parameter int N_RST       = 3,
   parameter int HOLD_CYCLES = 65535,
   parameter int STAGGER     = 256,
   parameter int SYNC_STAGES = 2,
   parameter int WDOG_W      = 24
) (
   input logic              clk,
   input logic              reset,
   reset_seq_ctrl_if.master bus
);
   localparam int CNT_MAX = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int REL_W   = $clog2(N_RST + 1);
   // The ASSERT cycle that first sees lock counts as the first hold cycle.
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLD_CYCLES >= 2) ? HOLD_CYCLES - 2 : 0);
   localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER - 1);
   localparam logic [REL_W-1:0] REL_LAST  = REL_W'(N_RST - 1);

   if (N_RST < 1 || HOLD_CYCLES < 1 || STAGGER < 1 || SYNC_STAGES < 2 || WDOG_W < 1) begin : g_bad_param
      $error("reset_seq_ctrl: illegal parameter value");
   end

   typedef enum logic [1:0] {S_ASSERT, S_HOLD, S_RELEASE, S_RUN} state_t;
   typedef enum logic [1:0] {C_POR = 2'b00, C_LOCK = 2'b01, C_SOFT = 2'b10, C_WDOG = 2'b11} cause_t;

   logic [SYNC_STAGES-1:0] r_rst_sync;
   logic [SYNC_STAGES-1:0] r_lock_sync;
   logic                   w_rst_rel;
   logic                   w_lock_s;

   state_t                 r_state, w_state_nxt;
   cause_t                 r_cause, w_cause_nxt;
   logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
   logic [REL_W-1:0]       r_rel, w_rel_nxt;
   logic [N_RST-1:0]       w_rst;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rst_sync  <= '0;
         r_lock_sync <= '0;
      end else begin
         r_rst_sync  <= {r_rst_sync[SYNC_STAGES-2:0], 1'b1};
         r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], bus.locked_i};
      end
   end

   assign w_rst_rel = r_rst_sync[SYNC_STAGES-1];
   assign w_lock_s  = r_lock_sync[SYNC_STAGES-1];

`ifdef RST_SEQ_WDOG_EN
   localparam logic [WDOG_W-1:0] WD_MAX = '1;
   logic [WDOG_W-1:0] r_wd, w_wd_nxt;
   logic              w_wd_exp;

   assign w_wd_exp = (r_state == S_RUN) && (r_wd == WD_MAX) && !bus.wdog_kick_i;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_wd <= '0;
      else       r_wd <= w_wd_nxt;
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_ASSERT;
         r_cause <= C_POR;
         r_cnt   <= '0;
         r_rel   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cause <= w_cause_nxt;
         r_cnt   <= w_cnt_nxt;
         r_rel   <= w_rel_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cause_nxt = r_cause;
      w_cnt_nxt   = r_cnt;
      w_rel_nxt   = r_rel;
`ifdef RST_SEQ_WDOG_EN
      w_wd_nxt    = '0;
`endif
      case (r_state)
         S_ASSERT: begin
            if (w_rst_rel && w_lock_s) begin
               w_state_nxt = S_HOLD;
               w_cnt_nxt   = '0;
            end
         end
         S_HOLD: begin
            if (r_cnt == HOLD_LAST) begin
               w_cnt_nxt = '0;
               if (N_RST == 1) begin
                  w_state_nxt = S_RUN;
               end else begin
                  w_state_nxt = S_RELEASE;
                  w_rel_nxt   = REL_W'(1);
               end
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         S_RELEASE: begin
            if (r_cnt == STAG_LAST) begin
               w_cnt_nxt = '0;
               w_rel_nxt = r_rel + 1'b1;
               if (r_rel == REL_LAST) w_state_nxt = S_RUN;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         S_RUN: begin
`ifdef RST_SEQ_WDOG_EN
            w_wd_nxt = bus.wdog_kick_i ? '0 : r_wd + 1'b1;
`endif
         end
         default: w_state_nxt = S_ASSERT;
      endcase

      // Re-entry overrides normal progress; priority lock loss > soft > watchdog.
      if (r_state != S_ASSERT) begin
         if (!w_lock_s) begin
            w_state_nxt = S_ASSERT;
            w_cause_nxt = C_LOCK;
         end else if (bus.soft_rst_i) begin
            w_state_nxt = S_ASSERT;
            w_cause_nxt = C_SOFT;
         end
`ifdef RST_SEQ_WDOG_EN
         else if (w_wd_exp) begin
            w_state_nxt = S_ASSERT;
            w_cause_nxt = C_WDOG;
         end
`endif
         if (w_state_nxt == S_ASSERT) begin
            w_cnt_nxt = '0;
            w_rel_nxt = '0;
`ifdef RST_SEQ_WDOG_EN
            w_wd_nxt  = '0;
`endif
         end
      end
   end

   always_comb begin
      w_rst = '1;
      case (r_state)
         S_RELEASE: begin
            for (int unsigned k = 0; k < N_RST; k++) w_rst[k] = (REL_W'(k) >= r_rel);
         end
         S_RUN:   w_rst = '0;
         default: w_rst = '1;
      endcase
   end

   assign bus.rst_o   = w_rst;
   assign bus.busy_o  = (r_state != S_RUN);
   assign bus.cause_o = r_cause;
endmodule
